// File: rtl/cr16_isa_pkg.sv
// CR16 instruction-set constants shared by the decode/operand-fetch slice.
package cr16_isa_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned IMM8_W  = 8;

  // Instruction field positions: [15:12] op, [11:8] rdest, [7:4] ext, [3:0] rsrc
  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 12;
  localparam int unsigned RDEST_MSB = 11;
  localparam int unsigned RDEST_LSB = 8;
  localparam int unsigned EXT_MSB   = 7;
  localparam int unsigned EXT_LSB   = 4;
  localparam int unsigned RSRC_MSB  = 3;
  localparam int unsigned RSRC_LSB  = 0;

  // Major opcodes
  localparam logic [FIELD_W-1:0] OP_RTYPE   = 4'b0000;
  localparam logic [FIELD_W-1:0] OP_ANDI    = 4'b0001;
  localparam logic [FIELD_W-1:0] OP_ORI     = 4'b0010;
  localparam logic [FIELD_W-1:0] OP_XORI    = 4'b0011;
  localparam logic [FIELD_W-1:0] OP_SPECIAL = 4'b0100;
  localparam logic [FIELD_W-1:0] OP_CMPI    = 4'b1011;
  localparam logic [FIELD_W-1:0] OP_BCOND   = 4'b1100;
  localparam logic [FIELD_W-1:0] OP_LUI     = 4'b1111;

  // Extension codes
  localparam logic [FIELD_W-1:0] EXT_LOAD = 4'b0000;
  localparam logic [FIELD_W-1:0] EXT_STOR = 4'b0100;
  localparam logic [FIELD_W-1:0] EXT_JUMP = 4'b1100;
  localparam logic [FIELD_W-1:0] EXT_CMP  = 4'b1011;

  // Logical immediates take a zero-extended imm8; all others sign-extend.
  function automatic logic is_logical_imm(input logic [FIELD_W-1:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/cr16_decoder.sv
// Combinational CR16 decoder: register read addresses, operand usage,
// write enable and the extended immediate for operand B.
module cr16_decoder
  import cr16_isa_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned REGISTER_BITS = 4
) (
  input  logic [INSTR_W-1:0]       instr,
  output logic [FIELD_W-1:0]       op_c,
  output logic [FIELD_W-1:0]       ext_c,
  output logic [REGISTER_BITS-1:0] dest_c,
  output logic [REGISTER_BITS-1:0] addr_a_c,
  output logic [REGISTER_BITS-1:0] addr_b_c,
  output logic                     use_a_c,
  output logic                     use_b_c,
  output logic                     we_c,
  output logic                     imm_sel_c,
  output logic [WIDTH-1:0]         imm_c
);

  logic [FIELD_W-1:0] op;
  logic [FIELD_W-1:0] rdest;
  logic [FIELD_W-1:0] ext;
  logic [FIELD_W-1:0] rsrc;
  logic [IMM8_W-1:0]  imm8;

  assign op    = instr[OP_MSB:OP_LSB];
  assign rdest = instr[RDEST_MSB:RDEST_LSB];
  assign ext   = instr[EXT_MSB:EXT_LSB];
  assign rsrc  = instr[RSRC_MSB:RSRC_LSB];
  assign imm8  = {ext, rsrc};

  assign op_c   = op;
  assign ext_c  = ext;
  assign dest_c = REGISTER_BITS'(rdest);

  // Operand routing per instruction class; unused read ports stay at r0.
  always_comb begin
    use_a_c   = 1'b0;
    use_b_c   = 1'b0;
    addr_a_c  = '0;
    addr_b_c  = '0;
    we_c      = 1'b0;
    imm_sel_c = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        use_a_c  = 1'b1;
        use_b_c  = 1'b1;
        addr_a_c = REGISTER_BITS'(rdest);
        addr_b_c = REGISTER_BITS'(rsrc);
        we_c     = (ext != EXT_CMP);
      end
      OP_SPECIAL: begin
        unique case (ext)
          EXT_LOAD: begin
            use_a_c  = 1'b1;
            addr_a_c = REGISTER_BITS'(rsrc);
            we_c     = 1'b1;
          end
          EXT_STOR: begin
            use_a_c  = 1'b1;
            use_b_c  = 1'b1;
            addr_a_c = REGISTER_BITS'(rsrc);
            addr_b_c = REGISTER_BITS'(rdest);
          end
          EXT_JUMP: begin
            use_a_c  = 1'b1;
            addr_a_c = REGISTER_BITS'(rsrc);
          end
          default: begin
          end
        endcase
      end
      OP_BCOND: begin
        // Branch displacement rides on operand B; no register reads.
        imm_sel_c = 1'b1;
      end
      default: begin
        use_a_c   = 1'b1;
        addr_a_c  = REGISTER_BITS'(rdest);
        imm_sel_c = 1'b1;
        we_c      = (op != OP_CMPI);
      end
    endcase
  end

  // Immediate extension: LUI shifts into the upper byte, logicals zero-extend.
  always_comb begin
    imm_c = {{(WIDTH-IMM8_W){imm8[IMM8_W-1]}}, imm8};
    if (op == OP_LUI) begin
      imm_c = WIDTH'({imm8, 8'h00});
    end else if (is_logical_imm(op)) begin
      imm_c = WIDTH'(imm8);
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// CR16 decode / operand-fetch stage: decodes, resolves operands with
// writeback forwarding, stalls on pending writes, and registers the bundle.
module operand_fetch_stage
  import cr16_isa_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned REGISTER_BITS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic [REGISTER_BITS-1:0] rf_addr1,
  output logic [REGISTER_BITS-1:0] rf_addr2,
  input  logic [WIDTH-1:0]         rf_data1,
  input  logic [WIDTH-1:0]         rf_data2,
  input  logic                     wb_valid,
  input  logic [REGISTER_BITS-1:0] wb_addr,
  input  logic [WIDTH-1:0]         wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FIELD_W-1:0]       out_op,
  output logic [FIELD_W-1:0]       out_ext,
  output logic [REGISTER_BITS-1:0] out_dest,
  output logic                     out_we,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b
);

  localparam int unsigned NUM_REGS = 1 << REGISTER_BITS;

  logic [FIELD_W-1:0]       dec_op;
  logic [FIELD_W-1:0]       dec_ext;
  logic [REGISTER_BITS-1:0] dec_dest;
  logic [REGISTER_BITS-1:0] dec_addr_a;
  logic [REGISTER_BITS-1:0] dec_addr_b;
  logic                     dec_use_a;
  logic                     dec_use_b;
  logic                     dec_we;
  logic                     dec_imm_sel;
  logic [WIDTH-1:0]         dec_imm;

  logic [WIDTH-1:0]         opnd_a_c;
  logic [WIDTH-1:0]         opnd_b_c;
  logic                     busy_a_c;
  logic                     busy_b_c;
  logic                     hazard_c;
  logic                     in_ready_c;
  logic                     accept_c;

  logic [NUM_REGS-1:0]      pending_q, pending_d;
  logic                     out_valid_q, out_valid_d;
  logic [FIELD_W-1:0]       out_op_q, out_op_d;
  logic [FIELD_W-1:0]       out_ext_q, out_ext_d;
  logic [REGISTER_BITS-1:0] out_dest_q, out_dest_d;
  logic                     out_we_q, out_we_d;
  logic [WIDTH-1:0]         out_a_q, out_a_d;
  logic [WIDTH-1:0]         out_b_q, out_b_d;

  cr16_decoder #(
    .WIDTH         (WIDTH),
    .REGISTER_BITS (REGISTER_BITS)
  ) u_decoder (
    .instr     (in_instr),
    .op_c      (dec_op),
    .ext_c     (dec_ext),
    .dest_c    (dec_dest),
    .addr_a_c  (dec_addr_a),
    .addr_b_c  (dec_addr_b),
    .use_a_c   (dec_use_a),
    .use_b_c   (dec_use_b),
    .we_c      (dec_we),
    .imm_sel_c (dec_imm_sel),
    .imm_c     (dec_imm)
  );

  assign rf_addr1 = dec_addr_a;
  assign rf_addr2 = dec_addr_b;

  // Operand resolution: a same-cycle writeback bypasses the register file,
  // whose write only lands on the capturing edge. r0 is never forwarded.
  always_comb begin
    opnd_a_c = '0;
    opnd_b_c = '0;
    if (dec_use_a) begin
      opnd_a_c = rf_data1;
      if (wb_valid && (wb_addr == dec_addr_a) && (dec_addr_a != '0)) begin
        opnd_a_c = wb_data;
      end
    end
    if (dec_use_b) begin
      opnd_b_c = rf_data2;
      if (wb_valid && (wb_addr == dec_addr_b) && (dec_addr_b != '0)) begin
        opnd_b_c = wb_data;
      end
    end else if (dec_imm_sel) begin
      opnd_b_c = dec_imm;
    end
  end

  // Read-after-write hazard and handshake; independent of in_valid.
  always_comb begin
    busy_a_c   = dec_use_a && (dec_addr_a != '0) && pending_q[dec_addr_a] &&
                 !(wb_valid && (wb_addr == dec_addr_a));
    busy_b_c   = dec_use_b && (dec_addr_b != '0) && pending_q[dec_addr_b] &&
                 !(wb_valid && (wb_addr == dec_addr_b));
    hazard_c   = busy_a_c || busy_b_c;
    in_ready_c = reset && !flush && !hazard_c && (!out_valid_q || out_ready);
    accept_c   = in_valid && in_ready_c;
  end

  assign in_ready = in_ready_c;

  // Scoreboard and output-register next state. Set after clears so an
  // accept wins over a same-cycle writeback to the same register.
  always_comb begin
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_ext_d   = out_ext_q;
    out_dest_d  = out_dest_q;
    out_we_d    = out_we_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;

    if (flush && out_valid_q && out_we_q) begin
      pending_d[out_dest_q] = 1'b0;
    end
    if (wb_valid) begin
      pending_d[wb_addr] = 1'b0;
    end
    if (accept_c && dec_we) begin
      pending_d[dec_dest] = 1'b1;
    end
    pending_d[0] = 1'b0;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept_c) begin
      out_valid_d = 1'b1;
      out_op_d    = dec_op;
      out_ext_d   = dec_ext;
      out_dest_d  = dec_dest;
      out_we_d    = dec_we;
      out_a_d     = opnd_a_c;
      out_b_d     = opnd_b_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_ext_q   <= '0;
      out_dest_q  <= '0;
      out_we_q    <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_ext_q   <= out_ext_d;
      out_dest_q  <= out_dest_d;
      out_we_q    <= out_we_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_ext   = out_ext_q;
  assign out_dest  = out_dest_q;
  assign out_we    = out_we_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: table vectors, directed corner sequences
// and randomized traffic, all checked against an instruction-level model.
module tb_operand_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [3:0]  rf_addr1;
  logic [3:0]  rf_addr2;
  logic [15:0] rf_data1;
  logic [15:0] rf_data2;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [3:0]  out_ext;
  logic [3:0]  out_dest;
  logic        out_we;
  logic [15:0] out_a;
  logic [15:0] out_b;

  operand_fetch_stage #(.WIDTH(16), .REGISTER_BITS(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .rf_addr1  (rf_addr1),
    .rf_addr2  (rf_addr2),
    .rf_data1  (rf_data1),
    .rf_data2  (rf_data2),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_ext   (out_ext),
    .out_dest  (out_dest),
    .out_we    (out_we),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  always #5 clock = ~clock;

  // Environment register file: r0 reads zero, writes land after the edge.
  logic [15:0] regs [16];
  assign rf_data1 = (rf_addr1 == 4'd0) ? 16'h0 : regs[rf_addr1];
  assign rf_data2 = (rf_addr2 == 4'd0) ? 16'h0 : regs[rf_addr2];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          pend [16];
  logic        m_valid;
  logic [3:0]  m_op, m_ext, m_dest;
  logic        m_we;
  logic [15:0] m_a, m_b;

  typedef struct packed {
    logic        use_a;
    logic        use_b;
    logic        we;
    logic        b_imm;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rd;
    logic [15:0] imm;
  } ref_dec_t;

  typedef struct packed {
    logic [15:0] instr;
    logic        wb_r0;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [15:0] a;
    logic [15:0] b;
    logic        we;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction semantics written per ISA class.
  function automatic ref_dec_t ref_decode(input logic [15:0] ins);
    ref_dec_t d;
    logic [3:0] op, rd, ext, rs;
    logic [7:0] imm8;
    op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; rs = ins[3:0];
    imm8 = ins[7:0];
    d = '0;
    d.rd = rd;
    if (op == 4'h0) begin
      d.use_a = 1; d.ra = rd; d.use_b = 1; d.rb = rs; d.we = (ext != 4'hB);
    end else if (op == 4'h4) begin
      if (ext == 4'h0) begin d.use_a = 1; d.ra = rs; d.we = 1; end
      else if (ext == 4'h4) begin d.use_a = 1; d.ra = rs; d.use_b = 1; d.rb = rd; end
      else if (ext == 4'hC) begin d.use_a = 1; d.ra = rs; end
    end else begin
      d.b_imm = 1;
      if (op == 4'hF) d.imm = 16'(imm8) * 16'd256;
      else if (op >= 4'h1 && op <= 4'h3) d.imm = 16'(imm8);
      else if (imm8 < 8'd128) d.imm = 16'(imm8);
      else d.imm = 16'(imm8) + 16'hFF00;
      if (op != 4'hC) begin d.use_a = 1; d.ra = rd; d.we = (op != 4'hB); end
    end
    return d;
  endfunction

  function automatic logic [15:0] opnd(input logic [3:0] r);
    if (r == 4'd0) return 16'h0;
    if (wb_valid && wb_addr == r) return wb_data;
    return regs[r];
  endfunction

  function automatic logic blocked(input ref_dec_t d);
    logic ba, bb;
    ba = d.use_a && d.ra != 0 && pend[d.ra] && !(wb_valid && wb_addr == d.ra);
    bb = d.use_b && d.rb != 0 && pend[d.rb] && !(wb_valid && wb_addr == d.rb);
    return ba || bb;
  endfunction

  // One clock: check combinational outputs, advance model, check registers.
  task automatic step();
    ref_dec_t d;
    logic exp_rdy, acc;
    logic [15:0] ea, eb;
    #1;
    d = ref_decode(in_instr);
    exp_rdy = reset && !flush && !blocked(d) && (!m_valid || out_ready);
    check("in_ready", 16'(in_ready), 16'(exp_rdy));
    check("rf_addr1", 16'(rf_addr1), 16'(d.use_a ? d.ra : 4'd0));
    check("rf_addr2", 16'(rf_addr2), 16'(d.use_b ? d.rb : 4'd0));
    acc = in_valid && exp_rdy;
    ea = d.use_a ? opnd(d.ra) : 16'h0;
    eb = d.use_b ? opnd(d.rb) : (d.b_imm ? d.imm : 16'h0);
    @(posedge clock);
    #1;
    if (!reset) begin
      for (int r = 0; r < 16; r++) pend[r] = 0;
      m_valid = 0; m_op = 0; m_ext = 0; m_dest = 0; m_we = 0; m_a = 0; m_b = 0;
    end else begin
      if (flush && m_valid && m_we) pend[m_dest] = 0;
      if (wb_valid) pend[wb_addr] = 0;
      if (acc && d.we && d.rd != 0) pend[d.rd] = 1;
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_op = in_instr[15:12]; m_ext = in_instr[7:4];
        m_dest = d.rd; m_we = d.we; m_a = ea; m_b = eb;
      end else if (out_ready) m_valid = 0;
    end
    if (wb_valid && wb_addr != 0) regs[wb_addr] = wb_data;
    check("out_valid", 16'(out_valid), 16'(m_valid));
    if (m_valid) begin
      check("out_op", 16'(out_op), 16'(m_op));
      check("out_ext", 16'(out_ext), 16'(m_ext));
      check("out_dest", 16'(out_dest), 16'(m_dest));
      check("out_we", 16'(out_we), 16'(m_we));
      check("out_a", out_a, m_a);
      check("out_b", out_b, m_b);
    end
  endtask

  task automatic idle_wb(input logic [3:0] r);
    in_valid = 0; wb_valid = 1; wb_addr = r; wb_data = regs[r];
    step();
    wb_valid = 0;
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      regs[r] = 16'(r) * 16'h0101;
      pend[r] = 0;
    end
    m_valid = 0; m_op = 0; m_ext = 0; m_dest = 0; m_we = 0; m_a = 0; m_b = 0;

    vecs[0]  = '{16'h0152, 1'b0, 4'd1, 4'd2, 16'h0101, 16'h0202, 1'b1}; // ADD r1,r2
    vecs[1]  = '{16'h03B4, 1'b0, 4'd3, 4'd4, 16'h0303, 16'h0404, 1'b0}; // CMP r3,r4
    vecs[2]  = '{16'h53FF, 1'b0, 4'd3, 4'd0, 16'h0303, 16'hFFFF, 1'b1}; // ADDI r3,#-1
    vecs[3]  = '{16'h1280, 1'b0, 4'd2, 4'd0, 16'h0202, 16'h0080, 1'b1}; // ANDI r2,#80
    vecs[4]  = '{16'h5280, 1'b0, 4'd2, 4'd0, 16'h0202, 16'hFF80, 1'b1}; // ADDI r2,#80
    vecs[5]  = '{16'hF712, 1'b0, 4'd7, 4'd0, 16'h0707, 16'h1200, 1'b1}; // LUI r7,#12
    vecs[6]  = '{16'hB507, 1'b0, 4'd5, 4'd0, 16'h0505, 16'h0007, 1'b0}; // CMPI r5,#7
    vecs[7]  = '{16'h4506, 1'b0, 4'd6, 4'd0, 16'h0606, 16'h0000, 1'b1}; // LOAD r5,(r6)
    vecs[8]  = '{16'h4546, 1'b0, 4'd6, 4'd5, 16'h0606, 16'h0505, 1'b0}; // STOR r5,(r6)
    vecs[9]  = '{16'h40C9, 1'b0, 4'd9, 4'd0, 16'h0909, 16'h0000, 1'b0}; // JUMP r9
    vecs[10] = '{16'hC2F0, 1'b0, 4'd0, 4'd0, 16'h0000, 16'hFFF0, 1'b0}; // BCOND
    vecs[11] = '{16'h0050, 1'b1, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b1}; // ADD r0,r0 + wb r0
    vecs[12] = '{16'h30FF, 1'b0, 4'd0, 4'd0, 16'h0000, 16'h00FF, 1'b1}; // XORI r0,#FF
    vecs[13] = '{16'h29F0, 1'b0, 4'd9, 4'd0, 16'h0909, 16'h00F0, 1'b1}; // ORI r9,#F0

    // Reset held two cycles with an instruction offered
    reset = 0; flush = 0; in_valid = 1; in_instr = 16'h0152; out_ready = 1;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    step();
    step();
    check("rst_in_ready", 16'(in_ready), 16'h0);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_out_fields", {out_op, out_ext, out_dest, 3'b0, out_we}, 16'h0);
    check("rst_out_a", out_a, 16'h0);
    check("rst_out_b", out_b, 16'h0);
    reset = 1; in_valid = 0;
    step();

    // Table vectors, each followed by a writeback that retires it
    for (int i = 0; i < 14; i++) begin
      in_valid = 1; in_instr = vecs[i].instr; out_ready = 1; flush = 0;
      wb_valid = vecs[i].wb_r0; wb_addr = 0; wb_data = 16'hDEAD;
      step();
      check($sformatf("vec%0d_rf_addr1", i), 16'(rf_addr1), 16'(vecs[i].a1));
      check($sformatf("vec%0d_rf_addr2", i), 16'(rf_addr2), 16'(vecs[i].a2));
      check($sformatf("vec%0d_valid", i), 16'(out_valid), 16'h1);
      check($sformatf("vec%0d_a", i), out_a, vecs[i].a);
      check($sformatf("vec%0d_b", i), out_b, vecs[i].b);
      check($sformatf("vec%0d_we", i), 16'(out_we), 16'(vecs[i].we));
      if (vecs[i].we) idle_wb(vecs[i].instr[11:8]);
      else begin in_valid = 0; wb_valid = 0; step(); end
    end

    // Back-to-back independent instructions
    in_valid = 1; in_instr = 16'h0152; out_ready = 1;
    step();
    check("b2b_first_valid", 16'(out_valid), 16'h1);
    in_instr = 16'h53FF;
    step();
    check("b2b_second_valid", 16'(out_valid), 16'h1);
    check("b2b_second_b", out_b, 16'hFFFF);
    check("b2b_second_we", 16'(out_we), 16'h1);
    idle_wb(4'd1);
    idle_wb(4'd3);

    // RAW stall resolved by a forwarded writeback
    in_valid = 1; in_instr = 16'h0152;
    step();
    in_instr = 16'h0491;
    step();
    check("raw_stall0", 16'(in_ready), 16'h0);
    step();
    check("raw_stall1", 16'(in_ready), 16'h0);
    wb_valid = 1; wb_addr = 4'd1; wb_data = 16'h1234;
    step();
    check("raw_fwd_valid", 16'(out_valid), 16'h1);
    check("raw_fwd_b", out_b, 16'h1234);
    idle_wb(4'd4);

    // Backpressure: bundle held for three cycles, then the next one loads
    in_valid = 1; in_instr = 16'h0152; out_ready = 1;
    step();
    out_ready = 0; in_instr = 16'h385A;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_ready", 16'(in_ready), 16'h0);
      check("bp_hold_op", 16'(out_op), 16'h0);
      check("bp_hold_a", out_a, 16'h1234);
    end
    out_ready = 1;
    step();
    check("bp_next_op", 16'(out_op), 16'h3);
    check("bp_next_b", out_b, 16'h005A);
    idle_wb(4'd1);
    idle_wb(4'd8);

    // Flush of a held LOAD releases its pending destination
    in_valid = 1; in_instr = 16'h4506; out_ready = 0;
    step();
    in_valid = 0;
    step();
    flush = 1;
    step();
    check("flush_valid", 16'(out_valid), 16'h0);
    flush = 0; in_valid = 1; in_instr = 16'h0655; out_ready = 1;
    #1;
    check("flush_no_stall", 16'(in_ready), 16'h1);
    step();
    check("flush_next_valid", 16'(out_valid), 16'h1);
    check("flush_next_b", out_b, 16'h0505);
    idle_wb(4'd6);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int n, k;
      logic [3:0] op;
      reset = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 11) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1: op = 4'h0;
        2, 3: op = 4'h4;
        4: op = 4'h5;
        5: op = 4'(1 + $urandom_range(0, 2));
        6: op = 4'hB;
        7: op = 4'hC;
        8: op = 4'hF;
        default: op = 4'(2 * $urandom_range(0, 7) + 1);
      endcase
      in_instr = {op, 4'($urandom_range(0, 7)), 4'($urandom), 4'($urandom_range(0, 7))};
      if (op == 4'h4) begin
        case ($urandom_range(0, 3))
          0: in_instr[7:4] = 4'h0;
          1: in_instr[7:4] = 4'h4;
          2: in_instr[7:4] = 4'hC;
          default: in_instr[7:4] = 4'h3;
        endcase
      end
      n = 0;
      for (int r = 1; r < 16; r++) if (pend[r]) n++;
      wb_data = 16'($urandom);
      if (n > 0 && $urandom_range(0, 2) != 0) begin
        k = int'($urandom_range(0, n - 1));
        wb_valid = 1;
        for (int r = 1; r < 16; r++) begin
          if (pend[r]) begin
            if (k == 0) wb_addr = 4'(r);
            k--;
          end
        end
      end else begin
        wb_valid = ($urandom_range(0, 7) == 0);
        wb_addr = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
